// File: rtl/imm_extend_unit.sv
// Immediate extension unit: combinational sign/zero/upper/branch/shamt extension
// feeding a 2-entry output FIFO with valid/ready handshakes on both sides.
module imm_extend_unit #(
    parameter int IN_SIZE    = 16,
    parameter int OUT_SIZE   = 32,
    parameter int SHAMT_LSB  = 6,
    parameter int SHAMT_SIZE = 5
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_flush,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [IN_SIZE-1:0]  i_imm,
    input  logic [2:0]          i_mode,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [OUT_SIZE-1:0] o_data,
    output logic                o_illegal
);

    typedef struct packed {
        logic                illegal;
        logic [OUT_SIZE-1:0] data;
    } entry_t;

    logic [OUT_SIZE-1:0] ext_sign;
    entry_t              ext;
    entry_t              ent0, ent1;   // ent0 is always the oldest entry
    logic [1:0]          count;
    logic                push, pop;

    assign ext_sign = {{(OUT_SIZE-IN_SIZE){i_imm[IN_SIZE-1]}}, i_imm};

    always_comb begin
        ext = '0;
        case (i_mode)
            3'b000:  ext.data = ext_sign;
            3'b001:  ext.data = {{(OUT_SIZE-IN_SIZE){1'b0}}, i_imm};
            3'b010:  ext.data = {i_imm, {(OUT_SIZE-IN_SIZE){1'b0}}};
            3'b011:  ext.data = ext_sign << 2;
            3'b100:  ext.data = OUT_SIZE'(i_imm[SHAMT_LSB+SHAMT_SIZE-1:SHAMT_LSB]);
            default: ext.illegal = 1'b1;
        endcase
    end

    assign o_ready = (count < 2'd2);
    assign o_valid = (count != 2'd0);
    assign push    = i_valid && o_ready && !i_flush;
    assign pop     = o_valid && i_ready && !i_flush;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (i_flush) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (push && pop) begin
            // push+pop only possible at count 1 (o_ready is low at 2)
            ent0 <= ext;
        end else if (push) begin
            count <= count + 2'd1;
            if (count == 2'd0) ent0 <= ext;
            else               ent1 <= ext;
        end else if (pop) begin
            count <= count - 2'd1;
            ent0  <= ent1;
            ent1  <= '0;
        end
    end

    assign o_data    = o_valid ? ent0.data    : '0;
    assign o_illegal = o_valid ? ent0.illegal : 1'b0;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Bench for imm_extend_unit: directed table, handshake corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_imm_extend_unit;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_imm = '0;
    logic [2:0]  i_mode = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_data;
    logic        o_illegal;

    int n_cmp = 0;
    int n_err = 0;

    imm_extend_unit dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_imm(i_imm), .i_mode(i_mode),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] imm;
        logic [2:0]  mode;
        logic [31:0] exp_d;
        logic        exp_il;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        il;
    } res_t;

    vec_t vecs[10];
    res_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: extension computed from integer arithmetic on the immediate.
    function automatic res_t ref_ext(input logic [15:0] imm, input logic [2:0] mode);
        res_t r;
        int   s;
        s = imm[15] ? int'(imm) - 65536 : int'(imm);
        r.il = 1'b0;
        case (mode)
            3'd0:    r.d = 32'(s);
            3'd1:    r.d = 32'(imm);
            3'd2:    r.d = 32'(imm) * 32'h10000;
            3'd3:    r.d = 32'(s * 4);
            3'd4:    r.d = (32'(imm) / 64) % 32;
            default: begin r.d = 32'd0; r.il = 1'b1; end
        endcase
        return r;
    endfunction

    task automatic drive(input logic v, input logic [15:0] imm, input logic [2:0] mode,
                         input logic rdy, input logic fl);
        i_valid = v; i_imm = imm; i_mode = mode; i_ready = rdy; i_flush = fl;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        drive(0, 16'h0, 3'd0, 0, 0);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        q.delete();
    endtask

    // One randomized cycle: check outputs against model, then advance model on the edge.
    task automatic rand_step();
        logic v, rdy, fl, psh, pp;
        logic [15:0] imm;
        logic [2:0] mode;
        @(negedge i_clk);
        v = 1'($urandom_range(0, 3) != 0);
        rdy = 1'($urandom_range(0, 2) != 0);
        fl = 1'($urandom_range(0, 31) == 0);
        imm = 16'($urandom);
        mode = 3'($urandom_range(0, 7));
        drive(v, imm, mode, rdy, fl);
        chk("rnd_o_ready", 32'(o_ready), 32'(q.size() < 2));
        chk("rnd_o_valid", 32'(o_valid), 32'(q.size() > 0));
        chk("rnd_o_data", o_data, q.size() > 0 ? q[0].d : 32'd0);
        chk("rnd_o_illegal", 32'(o_illegal), q.size() > 0 ? 32'(q[0].il) : 32'd0);
        psh = v && (q.size() < 2) && !fl;
        pp  = (q.size() > 0) && rdy && !fl;
        @(posedge i_clk);
        if (fl) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (psh) q.push_back(ref_ext(imm, mode));
        end
    endtask

    initial begin
        res_t a, b, d;
        vecs[0] = '{16'hFFFC, 3'd0, 32'hFFFFFFFC, 1'b0};
        vecs[1] = '{16'hFFFC, 3'd1, 32'h0000FFFC, 1'b0};
        vecs[2] = '{16'h8001, 3'd2, 32'h80010000, 1'b0};
        vecs[3] = '{16'h8001, 3'd3, 32'hFFFE0004, 1'b0};
        vecs[4] = '{16'h8001, 3'd4, 32'h00000000, 1'b0};
        vecs[5] = '{16'h07C0, 3'd4, 32'h0000001F, 1'b0};
        vecs[6] = '{16'h1234, 3'd6, 32'h00000000, 1'b1};
        vecs[7] = '{16'h1234, 3'd5, 32'h00000000, 1'b1};
        vecs[8] = '{16'h7FFF, 3'd0, 32'h00007FFF, 1'b0};
        vecs[9] = '{16'hFFFF, 3'd7, 32'h00000000, 1'b1};

        // Reset state
        #3;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_ready", 32'(o_ready), 32'd1);
        chk("rst_o_data", o_data, 32'd0);
        chk("rst_o_illegal", 32'(o_illegal), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Table: back-to-back offers with i_ready=1, result one cycle after each offer
        for (int i = 0; i <= 10; i++) begin
            @(negedge i_clk);
            if (i > 0) begin
                chk("tbl_o_valid", 32'(o_valid), 32'd1);
                chk("tbl_o_data", o_data, vecs[i-1].exp_d);
                chk("tbl_o_illegal", 32'(o_illegal), 32'(vecs[i-1].exp_il));
            end
            if (i < 10) drive(1, vecs[i].imm, vecs[i].mode, 1, 0);
            else        drive(0, 16'h0, 3'd0, 1, 0);
        end
        @(negedge i_clk);
        chk("tbl_drain_o_valid", 32'(o_valid), 32'd0);
        chk("tbl_drain_o_data", o_data, 32'd0);

        // Backpressure: A, B accepted, C refused, then A, B drain in order
        do_reset();
        a = ref_ext(16'h1111, 3'd0);
        b = ref_ext(16'hA222, 3'd3);
        drive(1, 16'h1111, 3'd0, 0, 0);
        chk("bp_ready_a", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        drive(1, 16'hA222, 3'd3, 0, 0);
        chk("bp_ready_b", 32'(o_ready), 32'd1);
        chk("bp_head_a", o_data, a.d);
        @(negedge i_clk);
        drive(1, 16'h3333, 3'd1, 0, 0);
        chk("bp_ready_c", 32'(o_ready), 32'd0);
        @(negedge i_clk);
        chk("bp_hold_a", o_data, a.d);
        chk("bp_hold_ready", 32'(o_ready), 32'd0);
        drive(0, 16'h0, 3'd0, 1, 0);
        @(negedge i_clk);
        chk("bp_pop1_ready", 32'(o_ready), 32'd1);
        chk("bp_second_b", o_data, b.d);
        chk("bp_second_valid", 32'(o_valid), 32'd1);
        @(negedge i_clk);
        chk("bp_empty_valid", 32'(o_valid), 32'd0);

        // Flush while full with an offer in the same cycle
        do_reset();
        drive(1, 16'h0AAA, 3'd1, 0, 0);
        @(negedge i_clk);
        drive(1, 16'h0BBB, 3'd1, 0, 0);
        @(negedge i_clk);
        drive(1, 16'h0CCC, 3'd1, 1, 1);
        @(negedge i_clk);
        drive(0, 16'h0, 3'd0, 1, 0);
        chk("fl_o_valid", 32'(o_valid), 32'd0);
        chk("fl_o_ready", 32'(o_ready), 32'd1);
        chk("fl_o_data", o_data, 32'd0);
        @(negedge i_clk);
        chk("fl_no_ghost", 32'(o_valid), 32'd0);

        // Async reset mid-cycle with one entry buffered
        do_reset();
        drive(1, 16'hFFF0, 3'd0, 0, 0);
        @(negedge i_clk);
        drive(0, 16'h0, 3'd0, 0, 0);
        chk("ar_pre_valid", 32'(o_valid), 32'd1);
        #2 i_reset = 1'b1;
        #1;
        chk("ar_o_valid", 32'(o_valid), 32'd0);
        chk("ar_o_data", o_data, 32'd0);
        chk("ar_o_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        i_reset = 1'b0;
        d = ref_ext(16'h0042, 3'd2);
        drive(1, 16'h0042, 3'd2, 1, 0);
        @(negedge i_clk);
        drive(0, 16'h0, 3'd0, 1, 0);
        chk("ar_first_valid", 32'(o_valid), 32'd1);
        chk("ar_first_data", o_data, d.d);

        // Randomized traffic against the queue model
        do_reset();
        for (int i = 0; i < 3000; i++) rand_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 Parameter IN_SIZE, default 16: width of the immediate field taken from the instruction; SHALL satisfy 11 <= IN_SIZE < OUT_SIZE.
REQ-002 Parameter OUT_SIZE, default 32: datapath word width.
REQ-003 Parameter SHAMT_LSB, default 6: low bit of the shift-amount field inside i_imm.
REQ-004 Parameter SHAMT_SIZE, default 5: width of the shift-amount field.
REQ-005 Port i_clk, input, 1: single clock, rising edge; the block SHALL use no other clock.
REQ-006 Port i_reset, input, 1: reset, asynchronous and active-high.
REQ-007 Port i_flush, input, 1: synchronous discard of all buffered results.
REQ-008 Port i_valid, input, 1: upstream offers i_imm and i_mode this cycle.
REQ-009 Port o_ready, output, 1: block accepts an offer this cycle.
REQ-010 Port i_imm, input, IN_SIZE: raw immediate field.
REQ-011 Port i_mode, input, 3: extension mode select.
REQ-012 Port o_valid, output, 1: o_data and o_illegal hold a valid result.
REQ-013 Port i_ready, input, 1: downstream consumes the result this cycle.
REQ-014 Port o_data, output, OUT_SIZE: extended value.
REQ-015 Port o_illegal, output, 1: the result came from an undefined mode.

Function
REQ-016 Mode 000 (sign) SHALL produce i_imm[IN_SIZE-1] replicated OUT_SIZE-IN_SIZE times, concatenated above i_imm.
REQ-017 Mode 001 (zero) SHALL produce zeros concatenated above i_imm.
REQ-018 Mode 010 (upper) SHALL produce i_imm in the top IN_SIZE bits and zeros in the low OUT_SIZE-IN_SIZE bits.
REQ-019 Mode 011 (branch) SHALL produce the mode-000 value shifted left by 2, truncated to OUT_SIZE bits, with zeros in bits [1:0].
REQ-020 Mode 100 (shamt) SHALL produce i_imm[SHAMT_LSB+SHAMT_SIZE-1:SHAMT_LSB] zero-extended to OUT_SIZE.
REQ-021 Modes 101, 110 and 111 SHALL produce o_data = 0 with o_illegal = 1; all other modes SHALL produce o_illegal = 0.
REQ-022 The block SHALL register results in a 2-entry FIFO output buffer that keeps o_illegal together with its data, with occupancy count 0..2.
REQ-023 o_ready SHALL be 1 when count < 2; this is a function of registered state only and SHALL NOT depend on i_ready.
REQ-024 A push SHALL occur when i_valid && o_ready && !i_flush.
REQ-025 A pop SHALL occur when o_valid && i_ready && !i_flush.
REQ-026 o_valid SHALL be 1 when count > 0; o_data and o_illegal SHALL show the oldest entry.
REQ-027 Latency SHALL be 1 cycle: a push into an empty buffer at edge N gives o_valid = 1 after edge N.
REQ-028 When a push and a pop happen in the same cycle, count SHALL stay the same and FIFO order SHALL be preserved.
REQ-029 When count = 2, i_valid SHALL be ignored and entries SHALL hold stable while i_ready = 0.
REQ-030 When count = 0, i_ready SHALL have no effect.
REQ-031 i_flush SHALL set count to 0 at the next edge, whatever i_valid and i_ready are; an offer in the flush cycle SHALL be dropped.
REQ-032 While o_valid = 0, o_data and o_illegal SHALL be 0.
REQ-033 Extension logic SHALL be purely combinational ahead of the buffer, with no extra pipeline stage.

Reset
REQ-034 On i_reset = 1, asynchronously: count = 0, o_valid = 0, o_data = 0, o_illegal = 0, storage cleared, o_ready = 1.
REQ-035 Reset asserted mid-transfer SHALL discard all entries; the first push after release SHALL be the first result seen.
REQ-036 After reset deasserts, the block SHALL accept a push on the first rising edge.

Verification
REQ-037 Sign/zero: i_imm = 16'hFFFC with modes 000 and 001 (i_ready = 1) -> o_data 32'hFFFFFFFC, then 32'h0000FFFC, one cycle after each offer, o_illegal = 0.
REQ-038 Upper/branch/shamt: i_imm = 16'h8001 with modes 010, 011 and 100 -> o_data 32'h80010000, 32'hFFFE0004, 32'h00000000; then i_imm = 16'h07C0 with mode 100 -> 32'h0000001F.
REQ-039 Illegal mode: mode 110 with i_imm = 16'h1234 -> o_data = 0, o_illegal = 1, o_valid = 1.
REQ-040 Backpressure: i_ready = 0, offer values A, B, C on consecutive cycles -> o_ready falls after B, C is not accepted; release i_ready -> output A then B in order, and o_ready returns to 1 after the first pop.
REQ-041 Flush: buffer full, i_flush = 1 with i_valid = 1 -> count = 0 and o_valid = 0 next cycle, and the offered value is never output.
REQ-042 Async reset: assert i_reset between clock edges with count = 1 -> o_valid and o_data go to 0 immediately, without waiting for a clock edge.
